// File: rtl/dcntr8_timer.sv
`default_nettype none
// ============================================================================
//  Module      : dcntr8_timer
//  Description : Loadable down-counter / timer. Counts a loaded value down to
//                zero, saturates there, pulses tc once on expiry and can
//                optionally restart from the last loaded value.
//  Ports       : clk         - system clock, rising edge
//                reset_n     - synchronous active-low reset
//                load        - load d_in into count and reload register
//                dec         - decrement enable
//                auto_reload - on expiry restart from the reload register
//                d_in        - load value
//                d_out       - current count (registered)
//                o_state     - current FSM state (registered)
//                tc          - terminal-count pulse (registered)
//                zero        - combinational, high when d_out == 0
//  Revision    : 1.0 - initial release
// ============================================================================
module dcntr8_timer #(
    parameter int WIDTH = 8,
    parameter int ST_W  = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             dec,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic [ST_W-1:0]  o_state,
    output logic             tc,
    output logic             zero
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_LOAD = 3'b001,
        ST_DEC  = 3'b010,
        ST_HOLD = 3'b011,
        ST_TC   = 3'b100
    } state_t;

    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (load) begin
            // Load wins over dec in the same cycle.
            count_d  = d_in;
            reload_d = d_in;
            state_d  = ST_LOAD;
        end else if (dec) begin
            if (state_q == ST_TC) begin
                // Expired: either restart or sit at zero without wrapping.
                if (auto_reload) begin
                    count_d = reload_q;
                    state_d = ST_LOAD;
                end
            end else if (count_q > C_ONE) begin
                count_d = count_q - C_ONE;
                state_d = ST_DEC;
            end else begin
                // Count of 1 or 0 (e.g. a load of 0) both expire now.
                count_d = '0;
                state_d = ST_TC;
                tc_d    = 1'b1;
            end
        end else if (state_q == ST_DEC) begin
            state_d = ST_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign d_out   = count_q;
    assign o_state = ST_W'(state_q);
    assign tc      = tc_q;
    assign zero    = (count_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_dcntr8_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcntr8_timer
//  Description : Directed self-checking bench for dcntr8_timer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dcntr8_timer;

    localparam logic [2:0] C_IDLE = 3'b000;
    localparam logic [2:0] C_LOAD = 3'b001;
    localparam logic [2:0] C_DEC  = 3'b010;
    localparam logic [2:0] C_HOLD = 3'b011;
    localparam logic [2:0] C_TC   = 3'b100;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       load = 1'b0;
    logic       dec = 1'b0;
    logic       auto_reload = 1'b0;
    logic [7:0] d_in = 8'h00;
    logic [7:0] d_out;
    logic [2:0] o_state;
    logic       tc;
    logic       zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dcntr8_timer #(.WIDTH(8), .ST_W(3)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (load),
        .dec         (dec),
        .auto_reload (auto_reload),
        .d_in        (d_in),
        .d_out       (d_out),
        .o_state     (o_state),
        .tc          (tc),
        .zero        (zero)
    );

    // Expected observation word {d_out, o_state, tc, zero}.
    function automatic logic [12:0] ev(input logic [7:0] d, input logic [2:0] s, input logic t);
        return {d, s, t, (d == 8'h00)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [12:0] got;
        reset_n = 1'b0; load = 1'b0; dec = 1'b0; auto_reload = 1'b0;
        tick(); tick();
        got = {d_out, o_state, tc, zero};
        total++;
        if (got !== ev(8'h00, C_IDLE, 1'b0)) begin
            bad++;
            $display("FAIL reset got=%h exp=%h", got, ev(8'h00, C_IDLE, 1'b0));
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            got = {d_out, o_state, tc, zero};
            total++;
            if (got !== ev(8'h00, C_IDLE, 1'b0)) begin
                bad++;
                $display("FAIL idle[%0d] got=%h exp=%h", i, got, ev(8'h00, C_IDLE, 1'b0));
            end
        end
    endtask

    task automatic test_countdown();
        logic [12:0] got;
        logic [12:0] exp_v [6];
        exp_v = '{ev(8'd3, C_LOAD, 1'b0), ev(8'd2, C_DEC, 1'b0), ev(8'd1, C_DEC, 1'b0),
                  ev(8'd0, C_TC, 1'b1), ev(8'd0, C_TC, 1'b0), ev(8'd0, C_TC, 1'b0)};
        load = 1'b1; d_in = 8'h03; dec = 1'b0; auto_reload = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            load = 1'b0; dec = 1'b1;
            got = {d_out, o_state, tc, zero};
            total++;
            if (got !== exp_v[i]) begin
                bad++;
                $display("FAIL countdown[%0d] got=%h exp=%h", i, got, exp_v[i]);
            end
        end
        dec = 1'b0;
    endtask

    task automatic test_auto_reload();
        logic [12:0] got;
        logic [12:0] exp_v [10];
        int pulses;
        exp_v = '{ev(8'd2, C_LOAD, 1'b0),
                  ev(8'd1, C_DEC, 1'b0), ev(8'd0, C_TC, 1'b1), ev(8'd2, C_LOAD, 1'b0),
                  ev(8'd1, C_DEC, 1'b0), ev(8'd0, C_TC, 1'b1), ev(8'd2, C_LOAD, 1'b0),
                  ev(8'd1, C_DEC, 1'b0), ev(8'd0, C_TC, 1'b1), ev(8'd2, C_LOAD, 1'b0)};
        pulses = 0;
        load = 1'b1; d_in = 8'h02; dec = 1'b0; auto_reload = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            load = 1'b0; dec = 1'b1;
            if (tc === 1'b1) pulses++;
            got = {d_out, o_state, tc, zero};
            total++;
            if (got !== exp_v[i]) begin
                bad++;
                $display("FAIL autoreload[%0d] got=%h exp=%h", i, got, exp_v[i]);
            end
        end
        total++;
        if (pulses !== 3) begin
            bad++;
            $display("FAIL autoreload_pulses got=%0d exp=3", pulses);
        end
        dec = 1'b0; auto_reload = 1'b0;
    endtask

    task automatic test_reload_zero();
        logic [12:0] got;
        logic [12:0] exp_v [5];
        exp_v = '{ev(8'd0, C_LOAD, 1'b0), ev(8'd0, C_TC, 1'b1), ev(8'd0, C_LOAD, 1'b0),
                  ev(8'd0, C_TC, 1'b1), ev(8'd0, C_LOAD, 1'b0)};
        load = 1'b1; d_in = 8'h00; dec = 1'b0; auto_reload = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            load = 1'b0; dec = 1'b1;
            got = {d_out, o_state, tc, zero};
            total++;
            if (got !== exp_v[i]) begin
                bad++;
                $display("FAIL reload_zero[%0d] got=%h exp=%h", i, got, exp_v[i]);
            end
        end
        dec = 1'b0; auto_reload = 1'b0;
    endtask

    task automatic test_pause_resume();
        logic [12:0] got;
        logic [12:0] exp_v [7];
        logic        dec_v [7];
        exp_v = '{ev(8'd5, C_LOAD, 1'b0), ev(8'd4, C_DEC, 1'b0), ev(8'd3, C_DEC, 1'b0),
                  ev(8'd3, C_HOLD, 1'b0), ev(8'd3, C_HOLD, 1'b0), ev(8'd3, C_HOLD, 1'b0),
                  ev(8'd2, C_DEC, 1'b0)};
        // dec value driven for the edge after each step; auto_reload toggled
        // here to show it is ignored outside the TC state.
        dec_v = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        load = 1'b1; d_in = 8'h05; dec = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            load = 1'b0; dec = dec_v[i]; auto_reload = ~auto_reload;
            got = {d_out, o_state, tc, zero};
            total++;
            if (got !== exp_v[i]) begin
                bad++;
                $display("FAIL pause[%0d] got=%h exp=%h", i, got, exp_v[i]);
            end
        end
        dec = 1'b0; auto_reload = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [12:0] got;
        load = 1'b1; d_in = 8'h06; dec = 1'b0;
        tick();
        load = 1'b0; dec = 1'b1;
        tick(); tick();
        got = {d_out, o_state, tc, zero};
        total++;
        if (got !== ev(8'd4, C_DEC, 1'b0)) begin
            bad++;
            $display("FAIL b2b_pre got=%h exp=%h", got, ev(8'd4, C_DEC, 1'b0));
        end
        load = 1'b1; dec = 1'b1; d_in = 8'h09;
        tick();
        got = {d_out, o_state, tc, zero};
        total++;
        if (got !== ev(8'd9, C_LOAD, 1'b0)) begin
            bad++;
            $display("FAIL b2b_load got=%h exp=%h", got, ev(8'd9, C_LOAD, 1'b0));
        end
        load = 1'b0;
        tick();
        got = {d_out, o_state, tc, zero};
        total++;
        if (got !== ev(8'd8, C_DEC, 1'b0)) begin
            bad++;
            $display("FAIL b2b_dec got=%h exp=%h", got, ev(8'd8, C_DEC, 1'b0));
        end
        dec = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [12:0] got;
        load = 1'b1; d_in = 8'h08; dec = 1'b0;
        tick();
        load = 1'b0; dec = 1'b1;
        tick(); tick();
        got = {d_out, o_state, tc, zero};
        total++;
        if (got !== ev(8'd6, C_DEC, 1'b0)) begin
            bad++;
            $display("FAIL rstmid_pre got=%h exp=%h", got, ev(8'd6, C_DEC, 1'b0));
        end
        reset_n = 1'b0;
        tick();
        got = {d_out, o_state, tc, zero};
        total++;
        if (got !== ev(8'd0, C_IDLE, 1'b0)) begin
            bad++;
            $display("FAIL rstmid got=%h exp=%h", got, ev(8'd0, C_IDLE, 1'b0));
        end
        reset_n = 1'b1;
        tick();
        got = {d_out, o_state, tc, zero};
        total++;
        if (got !== ev(8'd0, C_TC, 1'b1)) begin
            bad++;
            $display("FAIL rstmid_expire got=%h exp=%h", got, ev(8'd0, C_TC, 1'b1));
        end
        // Low pulse confined between edges must be ignored.
        load = 1'b1; d_in = 8'h07; dec = 1'b0;
        tick();
        load = 1'b0;
        #1 reset_n = 1'b0;
        #3 reset_n = 1'b1;
        tick();
        got = {d_out, o_state, tc, zero};
        total++;
        if (got !== ev(8'd7, C_LOAD, 1'b0)) begin
            bad++;
            $display("FAIL rst_glitch got=%h exp=%h", got, ev(8'd7, C_LOAD, 1'b0));
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_auto_reload();
        test_reload_zero();
        test_pause_resume();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
